// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit_pkg : shared types and constants for the RV32 fetch stage
// Revision: 1.0
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_REQ     = 3'd1,
        FS_WAIT    = 3'd2,
        FS_HOLD    = 3'd3,
        FS_BR_WAIT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : single-outstanding instruction fetch, IF->ID valid/ready producer
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        branch_i,
    input  logic        br_resolve_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i
);

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  inst_q;
    logic [31:0]  pc_q;
    logic [31:0]  jmp_tgt_q;
    logic [31:0]  br_npc_q;
    logic         jmp_pend_q;
    logic         br_pend_q;
    logic         br_done_q;

    logic [31:0]  br_npc_d;
    logic [31:0]  jmp_tgt_d;
    logic [31:0]  br_sel_npc_d;
    logic         jmp_pend_d;
    logic         br_pend_d;
    logic         br_done_d;

    // Redirects raised in the handoff cycle itself are folded in here.
    assign br_npc_d     = br_taken_i ? br_target_i : seq_pc(pc_q);
    assign jmp_tgt_d    = jmp_i ? jmp_target_i : jmp_tgt_q;
    assign jmp_pend_d   = jmp_pend_q | jmp_i;
    assign br_pend_d    = br_pend_q | branch_i;
    assign br_done_d    = br_done_q | (br_pend_q & br_resolve_i);
    assign br_sel_npc_d = br_done_q ? br_npc_q : br_npc_d;

    assign imem_req_o  = (state_q == FS_REQ);
    assign imem_addr_o = fetch_pc_q;
    assign valid_o     = (state_q == FS_HOLD);
    assign inst_o      = inst_q;
    assign pc_o        = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            inst_q     <= 32'd0;
            pc_q       <= RESET_PC;
            jmp_tgt_q  <= 32'd0;
            br_npc_q   <= 32'd0;
            jmp_pend_q <= 1'b0;
            br_pend_q  <= 1'b0;
            br_done_q  <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: state_q <= FS_REQ;
                FS_REQ:  state_q <= FS_WAIT;
                FS_WAIT: begin
                    if (imem_rvalid_i) begin
                        inst_q  <= imem_rdata_i;
                        pc_q    <= fetch_pc_q;
                        state_q <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (ready_i) begin
                        jmp_pend_q <= 1'b0;
                        br_pend_q  <= 1'b0;
                        br_done_q  <= 1'b0;
                        if (jmp_pend_d) begin
                            fetch_pc_q <= jmp_tgt_d;
                            state_q    <= FS_REQ;
                        end else if (br_pend_d && br_done_d) begin
                            fetch_pc_q <= br_sel_npc_d;
                            state_q    <= FS_REQ;
                        end else if (br_pend_d) begin
                            state_q    <= FS_BR_WAIT;
                        end else begin
                            fetch_pc_q <= seq_pc(pc_q);
                            state_q    <= FS_REQ;
                        end
                    end else begin
                        if (jmp_i) begin
                            jmp_pend_q <= 1'b1;
                            jmp_tgt_q  <= jmp_target_i;
                        end
                        if (branch_i) begin
                            br_pend_q <= 1'b1;
                        end
                        // First resolution of the pending branch is the one kept.
                        if (br_pend_q && br_resolve_i && !br_done_q) begin
                            br_done_q <= 1'b1;
                            br_npc_q  <= br_npc_d;
                        end
                    end
                end
                FS_BR_WAIT: begin
                    if (br_resolve_i) begin
                        fetch_pc_q <= br_npc_d;
                        state_q    <= FS_REQ;
                    end
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        jmp_i;
    logic [31:0] jmp_target_i;
    logic        branch_i;
    logic        br_resolve_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;

    logic        mem_rvalid_q;
    logic [31:0] mem_rdata_q;
    logic        inj_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0010_0093 ^ {a[23:0], 8'h00};
    endfunction

    // Memory answers every request exactly one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid_q <= 1'b0;
            mem_rdata_q  <= 32'd0;
        end else begin
            mem_rvalid_q <= imem_req_o;
            mem_rdata_q  <= memf(imem_addr_o);
        end
    end

    assign imem_rvalid_i = mem_rvalid_q | inj_rvalid;
    assign imem_rdata_i  = inj_rvalid ? 32'hDEAD_BEEF : mem_rdata_q;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .branch_i     (branch_i),
        .br_resolve_i (br_resolve_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i)
    );

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!valid_o && k < 12) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: valid_o=%b required 1 within 12 cycles", tag, valid_o);
        end
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        jmp_i = 1'b1; jmp_target_i = tgt; ready_i = 1'b1;
        @(negedge clk);
        jmp_i = 1'b0; ready_i = 1'b0;
        wait_valid("jump_to");
    endtask

    task automatic test_reset;
        n_checks++;
        if (valid_o !== 1'b0 || inst_o !== 32'd0 || pc_o !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b inst=%h pc=%h required 0/0/%h", valid_o, inst_o, pc_o, RESET_PC);
        end
        n_checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_req: req=%b addr=%h required 0/%h", imem_req_o, imem_addr_o, RESET_PC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h required 1/0", imem_req_o, imem_addr_o);
        end
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_state: valid=%b req=%b required 0/0", valid_o, imem_req_o);
        end
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h0010_0093) begin
            n_fail++;
            $display("FAIL first_valid: valid=%b pc=%h inst=%h required 1/0/00100093", valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_first_handoff;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            n_fail++;
            $display("FAIL handoff_seq: valid=%b req=%b addr=%h required 0/1/4", valid_o, imem_req_o, imem_addr_o);
        end
        wait_valid("seq4");
        n_checks++;
        if (pc_o !== 32'h4 || inst_o !== memf(32'h4)) begin
            n_fail++;
            $display("FAIL seq4_data: pc=%h inst=%h required 4/%h", pc_o, inst_o, memf(32'h4));
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 32'h4 || inst_o !== memf(32'h4)) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: valid=%b req=%b pc=%h inst=%h required 1/0/4/%h",
                         i, valid_o, imem_req_o, pc_o, inst_o, memf(32'h4));
            end
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b req=%b addr=%h required 0/1/8", valid_o, imem_req_o, imem_addr_o);
        end
        wait_valid("seq8");
    endtask

    task automatic test_jump;
        jump_to(32'h10);
        n_checks++;
        if (pc_o !== 32'h10) begin
            n_fail++;
            $display("FAIL jump_same_cycle: pc=%h required 10", pc_o);
        end
        jmp_i = 1'b1; jmp_target_i = 32'h300;
        @(negedge clk);
        jmp_target_i = 32'h200;
        @(negedge clk);
        jmp_i = 1'b0; jmp_target_i = 32'h0;
        repeat (3) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            n_fail++;
            $display("FAIL jump_req: req=%b addr=%h required 1/200", imem_req_o, imem_addr_o);
        end
        wait_valid("jump");
        n_checks++;
        if (pc_o !== 32'h200 || inst_o !== memf(32'h200)) begin
            n_fail++;
            $display("FAIL jump_data: pc=%h inst=%h required 200/%h", pc_o, inst_o, memf(32'h200));
        end
    endtask

    task automatic branch_after(input logic taken, input logic [31:0] exp_addr);
        jump_to(32'h20);
        branch_i = 1'b1;
        @(negedge clk);
        branch_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL br_wait_idle[%0d]: valid=%b req=%b required 0/0", i, valid_o, imem_req_o);
            end
            @(negedge clk);
        end
        br_resolve_i = 1'b1; br_taken_i = taken; br_target_i = 32'h80;
        @(negedge clk);
        br_resolve_i = 1'b0; br_taken_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== exp_addr) begin
            n_fail++;
            $display("FAIL br_after_req(t=%b): req=%b addr=%h required 1/%h", taken, imem_req_o, imem_addr_o, exp_addr);
        end
        wait_valid("br_after");
        n_checks++;
        if (pc_o !== exp_addr) begin
            n_fail++;
            $display("FAIL br_after_pc: pc=%h required %h", pc_o, exp_addr);
        end
    endtask

    task automatic test_branch_before;
        jump_to(32'h20);
        branch_i = 1'b1;
        @(negedge clk);
        branch_i = 1'b0;
        br_resolve_i = 1'b1; br_taken_i = 1'b0; br_target_i = 32'h80;
        @(negedge clk);
        br_resolve_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h24) begin
            n_fail++;
            $display("FAIL br_before_req: req=%b addr=%h required 1/24", imem_req_o, imem_addr_o);
        end
        wait_valid("br_before");
    endtask

    task automatic test_misc;
        br_resolve_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h999;
        @(negedge clk);
        br_resolve_i = 1'b0; br_taken_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h28) begin
            n_fail++;
            $display("FAIL stray_resolve: req=%b addr=%h required 1/28", imem_req_o, imem_addr_o);
        end
        @(negedge clk);
        ready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h28) begin
            n_fail++;
            $display("FAIL ready_no_valid: valid=%b pc=%h required 1/28", valid_o, pc_o);
        end
        jmp_i = 1'b1; jmp_target_i = 32'h40; branch_i = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        jmp_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            n_fail++;
            $display("FAIL jmp_beats_branch: req=%b addr=%h required 1/40", imem_req_o, imem_addr_o);
        end
        wait_valid("conflict");
    endtask

    task automatic test_wrap_reset;
        jump_to(32'hFFFF_FFFC);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: req=%b addr=%h required 1/0", imem_req_o, imem_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || pc_o !== RESET_PC || inst_o !== 32'd0 || imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b pc=%h inst=%h req=%b required 0/%h/0/0",
                     valid_o, pc_o, inst_o, imem_req_o, RESET_PC);
        end
        @(negedge clk);
        inj_rvalid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        inj_rvalid = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart_req: req=%b addr=%h required 1/%h", imem_req_o, imem_addr_o, RESET_PC);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== RESET_PC || inst_o !== 32'h0010_0093) begin
            n_fail++;
            $display("FAIL restart_data: valid=%b pc=%h inst=%h required 1/%h/00100093", valid_o, pc_o, inst_o, RESET_PC);
        end
    endtask

    initial begin
        rst_n = 1'b0; ready_i = 1'b0; jmp_i = 1'b0; jmp_target_i = 32'd0;
        branch_i = 1'b0; br_resolve_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'd0;
        inj_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_first_handoff;
        test_hold;
        test_jump;
        branch_after(1'b1, 32'h80);
        branch_after(1'b0, 32'h24);
        test_branch_before;
        test_misc;
        test_wrap_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
